// File: rtl/fir_pkg.sv
// Shared constants, default coefficients and MAC sequencer states for the
// 5-tap symmetric FIR datapath.
package fir_pkg;

  localparam int DATA_W = 10;
  localparam int COEF_W = 8;
  localparam int ACC_W  = DATA_W + COEF_W + 3;

  localparam logic signed [COEF_W-1:0] C0_DEF = 8'sd8;
  localparam logic signed [COEF_W-1:0] C1_DEF = 8'sd24;
  localparam logic signed [COEF_W-1:0] C2_DEF = 8'sd32;

  typedef enum logic [2:0] {
    IDLE,
    MAC0,
    MAC1,
    MAC2,
    DONE
  } macState_e;

endpackage

// File: rtl/sym_preadd.sv
// Combinational pre-adder that folds the symmetric tap pairs into one word each,
// sign-extended by one bit so the pair sums can never wrap.
module sym_preadd #(
  parameter int DATA_W = 10
) (
  input  logic signed [DATA_W-1:0] x0,
  input  logic signed [DATA_W-1:0] x1,
  input  logic signed [DATA_W-1:0] x2,
  input  logic signed [DATA_W-1:0] x3,
  input  logic signed [DATA_W-1:0] x4,
  output logic signed [DATA_W:0]   p0,
  output logic signed [DATA_W:0]   p1,
  output logic signed [DATA_W:0]   p2
);

  localparam int PRE_W = DATA_W + 1;

  // The centre tap is widened too so all three share one multiplier operand width.
  assign p0 = PRE_W'(x0) + PRE_W'(x4);
  assign p1 = PRE_W'(x1) + PRE_W'(x3);
  assign p2 = PRE_W'(x2);

endmodule

// File: rtl/fir5_sym_mac.sv
// Symmetric 5-tap FIR output stage: one tap snapshot in, three sequential MAC
// steps on a single shared multiplier, full-precision result out via valid/ready.
module fir5_sym_mac
  import fir_pkg::*;
#(
  parameter int                        DATA_W = fir_pkg::DATA_W,
  parameter int                        COEF_W = fir_pkg::COEF_W,
  parameter logic signed [COEF_W-1:0]  C0     = fir_pkg::C0_DEF,
  parameter logic signed [COEF_W-1:0]  C1     = fir_pkg::C1_DEF,
  parameter logic signed [COEF_W-1:0]  C2     = fir_pkg::C2_DEF,
  parameter int                        ACC_W  = DATA_W + COEF_W + 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] x0,
  input  logic signed [DATA_W-1:0] x1,
  input  logic signed [DATA_W-1:0] x2,
  input  logic signed [DATA_W-1:0] x3,
  input  logic signed [DATA_W-1:0] x4,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [ACC_W-1:0]  y,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int PRE_W  = DATA_W + 1;
  localparam int PROD_W = PRE_W + COEF_W;

  macState_e state_q, state_d;

  logic signed [PRE_W-1:0]  p0_q, p1_q, p2_q;
  logic signed [PRE_W-1:0]  p0_d, p1_d, p2_d;
  logic signed [PRE_W-1:0]  preP0, preP1, preP2;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  y_q, y_d;
  logic                     outValid_q, outValid_d;

  logic signed [PRE_W-1:0]  mulPre;
  logic signed [COEF_W-1:0] mulCoef;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prodExt;
  logic                     accept;

  sym_preadd #(
    .DATA_W (DATA_W)
  ) uPreadd (
    .x0 (x0),
    .x1 (x1),
    .x2 (x2),
    .x3 (x3),
    .x4 (x4),
    .p0 (preP0),
    .p1 (preP1),
    .p2 (preP2)
  );

  assign accept = in_valid & in_ready;

  // Both operands are widened to the full product width before multiplying so
  // the signed product is exact.
  assign prod    = PROD_W'(mulPre) * PROD_W'(mulCoef);
  assign prodExt = ACC_W'(prod);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      p0_q       <= '0;
      p1_q       <= '0;
      p2_q       <= '0;
      acc_q      <= '0;
      y_q        <= '0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      p0_q       <= p0_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      acc_q      <= acc_d;
      y_q        <= y_d;
      outValid_q <= outValid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = MAC0;
      MAC0:    state_d = MAC1;
      MAC1:    state_d = MAC2;
      MAC2:    state_d = DONE;
      DONE:    if (out_ready) state_d = in_valid ? MAC0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    mulPre     = '0;
    mulCoef    = '0;
    acc_d      = acc_q;
    y_d        = y_q;
    outValid_d = outValid_q;
    p0_d       = p0_q;
    p1_d       = p1_q;
    p2_d       = p2_q;

    if (accept) begin
      p0_d = preP0;
      p1_d = preP1;
      p2_d = preP2;
    end

    case (state_q)
      MAC0: begin
        mulPre  = p0_q;
        mulCoef = C0;
        acc_d   = prodExt;
      end
      MAC1: begin
        mulPre  = p1_q;
        mulCoef = C1;
        acc_d   = acc_q + prodExt;
      end
      MAC2: begin
        mulPre     = p2_q;
        mulCoef    = C2;
        y_d        = acc_q + prodExt;
        outValid_d = 1'b1;
      end
      DONE: if (out_ready) outValid_d = 1'b0;
      default: ;
    endcase
  end

  assign y         = y_q;
  assign out_valid = outValid_q;

endmodule

// File: tb/tb_fir5_sym_mac.sv
// Bench for fir5_sym_mac: table vectors plus hand-written handshake sequences,
// with every produced result checked against a queue of expected values.
module tb_fir5_sym_mac;

  localparam int DW = 10;
  localparam int AW = 21;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] x0, x1, x2, x3, x4;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [AW-1:0] y;
  logic                 out_valid;
  logic                 out_ready;

  fir5_sym_mac dut (
    .clk       (clk),
    .rst       (rst),
    .x0        (x0),
    .x1        (x1),
    .x2        (x2),
    .x3        (x3),
    .x4        (x4),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int expY;
    int acceptCyc;
    bit checkLat;
    bit checkStride;
  } sbEntry_t;

  typedef struct {
    int t [5];
    int expY;
  } vec_t;

  sbEntry_t sbQ [$];
  sbEntry_t popE;
  vec_t     vecs [8];
  int       total   = 0;
  int       bad     = 0;
  int       lastPop = 0;

  function automatic int golden(input int a0, input int a1, input int a2,
                                input int a3, input int a4);
    return 8 * (a0 + a4) + 24 * (a1 + a3) + 32 * a2;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  // Results are retired at the negative edge before the handshake edge, when
  // y and out_valid are settled.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected out_valid", out_valid, 0);
      end else begin
        popE = sbQ.pop_front();
        checkOutput("y", y, popE.expY);
        if (popE.checkLat)    checkOutput("latency", cyc - popE.acceptCyc, 3);
        if (popE.checkStride) checkOutput("stride", cyc - lastPop, 4);
      end
      lastPop = cyc;
    end
  end

  task automatic applyStimulus(input int t0, input int t1, input int t2, input int t3,
                               input int t4, input int expY, input bit lat, input bit stride);
    x0 = DW'(t0);
    x1 = DW'(t1);
    x2 = DW'(t2);
    x3 = DW'(t3);
    x4 = DW'(t4);
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sbQ.push_back('{expY, cyc + 1, lat, stride});
        @(posedge clk);
        #1;
        return;
      end
    end
    checkOutput("accept timeout", in_ready, 1);
  endtask

  task automatic waitDrain();
    in_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sbQ.size() == 0) break;
    end
    checkOutput("drain", sbQ.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{'{511, 511, 511, 511, 511}, 49056};
    vecs[1] = '{'{-512, -512, -512, -512, -512}, -49152};
    vecs[2] = '{'{10, -20, 30, -20, 10}, 160};
    vecs[3] = '{'{0, 0, 0, 0, -7}, -56};
    vecs[4] = '{'{0, 1, 0, 0, 0}, 24};
    vecs[5] = '{'{0, 0, 1, 0, 0}, 32};
    vecs[6] = '{'{3, -5, 7, 2, -1}, 168};
    vecs[7] = '{'{0, 0, 0, -1, 0}, -24};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    {x0, x1, x2, x3, x4} = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset y", y, 0);
    checkOutput("reset in_ready", in_ready, 1);

    $display("[TB] impulse with busy-phase checks");
    applyStimulus(100, 0, 0, 0, 0, 800, 1, 0);
    in_valid = 1'b1;
    x0 = 10'sd55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("busy in_ready", in_ready, 0);
      checkOutput("early out_valid", out_valid, 0);
    end
    waitDrain();

    $display("[TB] table vectors");
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].t[0], vecs[v].t[1], vecs[v].t[2], vecs[v].t[3],
                    vecs[v].t[4], vecs[v].expY, 1, 0);
      waitDrain();
    end

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(3, -5, 7, 2, -1, 168, 0, 0);
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    checkOutput("bp out_valid rise", out_valid, 1);
    @(posedge clk);
    #1;
    x0 = -10'sd512; x1 = 10'sd511; x2 = -10'sd1; x3 = 10'sd0; x4 = 10'sd77;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("bp out_valid hold", out_valid, 1);
      checkOutput("bp y hold", y, 168);
      checkOutput("bp in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(-512, 511, -1, 0, 77, golden(-512, 511, -1, 0, 77), 1, 0);
    waitDrain();

    $display("[TB] streaming");
    for (int k = 0; k < 8; k++) begin
      int r [5];
      for (int j = 0; j < 5; j++) r[j] = int'($urandom_range(1023)) - 512;
      applyStimulus(r[0], r[1], r[2], r[3], r[4],
                    golden(r[0], r[1], r[2], r[3], r[4]), 1, k > 0);
    end
    waitDrain();

    $display("[TB] reset during MAC1");
    applyStimulus(50, 50, 50, 50, 50, golden(50, 50, 50, 50, 50), 1, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbQ.delete();
    checkOutput("abort out_valid", out_valid, 0);
    checkOutput("abort y", y, 0);
    checkOutput("abort in_ready", in_ready, 1);
    applyStimulus(100, 0, 0, 0, 0, 800, 1, 0);
    waitDrain();
    repeat (8) @(posedge clk);
    #1;
    checkOutput("final scoreboard", sbQ.size(), 0);
    checkOutput("final out_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
